// File: rtl/sie_pkg.sv
// sie_pkg: SIE phase codes and Q14 constants shared by the phase sequencer and coupling_mode_controller.
package sie_pkg;

    localparam logic [2:0] SIE_BASELINE     = 3'd0;
    localparam logic [2:0] SIE_PRE_IGNITION = 3'd1;
    localparam logic [2:0] SIE_IGNITION     = 3'd2;
    localparam logic [2:0] SIE_PLATEAU      = 3'd3;
    localparam logic [2:0] SIE_PROPAGATION  = 3'd4;
    localparam logic [2:0] SIE_DECAY        = 3'd5;
    localparam logic [2:0] SIE_REFRACTORY   = 3'd6;

    localparam int ONE = 16384;

    typedef enum logic [2:0] {
        PH_BASELINE    = SIE_BASELINE,
        PH_PRE         = SIE_PRE_IGNITION,
        PH_IGNITION    = SIE_IGNITION,
        PH_PLATEAU     = SIE_PLATEAU,
        PH_PROPAGATION = SIE_PROPAGATION,
        PH_DECAY       = SIE_DECAY,
        PH_REFRACTORY  = SIE_REFRACTORY,
        PH_ILLEGAL     = 3'd7
    } sie_phase_e;

    function automatic bit dur_ok(input int n);
        return n >= 1 && n <= 65535;
    endfunction

endpackage

// File: rtl/sie_envelope_ramp.sv
// sie_envelope_ramp: saturating Q14 envelope register stepped up or down by fixed amounts.
module sie_envelope_ramp
    import sie_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int UP    = 256,
    parameter int DN    = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    up,
    input  logic                    down,
    input  logic                    hold_one,
    input  logic                    clear,
    input  logic                    force_one,
    input  logic                    force_zero,
    output logic signed [WIDTH-1:0] env
);

    localparam logic signed [WIDTH-1:0] ONE_W = WIDTH'(ONE);
    localparam logic signed [WIDTH-1:0] UP_W  = WIDTH'(UP);
    localparam logic signed [WIDTH-1:0] DN_W  = WIDTH'(DN);

    logic signed [WIDTH-1:0] env_q, env_d;

    // With no control asserted the envelope simply holds its value.
    always_comb begin
        env_d = (clear || force_zero) ? '0
              : (force_one || hold_one) ? ONE_W
              : up ? ((env_q >= ONE_W - UP_W) ? ONE_W : env_q + UP_W)
              : down ? ((env_q <= DN_W) ? '0 : env_q - DN_W)
              : env_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) env_q <= '0;
        else env_q <= env_d;
    end

    assign env = env_q;

endmodule

// File: rtl/sie_phase_sequencer.sv
// sie_phase_sequencer: debounced SIE trigger and timed ignition/plateau/propagation/decay/refractory
// sequence producing the phase code, activity flag, Q14 envelope and ignition counter.
module sie_phase_sequencer
    import sie_pkg::*;
#(
    parameter int WIDTH                  = 18,
    parameter int FRAC                   = 14,
    parameter int PRE_CYCLES             = 32,
    parameter int IGNITION_CYCLES        = 64,
    parameter int PLATEAU_CYCLES         = 256,
    parameter int PROPAGATION_CYCLES     = 128,
    parameter int DECAY_CYCLES           = 256,
    parameter int REFRACTORY_CYCLES      = 512,
    parameter int DEFAULT_TRIGGER_THRESH = 6554,
    parameter int DEFAULT_R_GATE         = 7373
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic                    enable,
    input  logic                    force_trigger,
    input  logic signed [WIDTH-1:0] boundary_power,
    input  logic signed [WIDTH-1:0] kuramoto_R,
    input  logic signed [WIDTH-1:0] trigger_thresh,
    input  logic signed [WIDTH-1:0] r_gate,
    output logic [2:0]              sie_phase,
    output logic                    sie_active,
    output logic signed [WIDTH-1:0] sie_envelope,
    output logic                    ignition_pulse,
    output logic [15:0]             event_count
);

    if (!(dur_ok(PRE_CYCLES) && dur_ok(IGNITION_CYCLES) && dur_ok(PLATEAU_CYCLES) &&
          dur_ok(PROPAGATION_CYCLES) && dur_ok(DECAY_CYCLES) && dur_ok(REFRACTORY_CYCLES) &&
          ONE == (1 << FRAC))) begin : g_bad_params
        $error("sie_phase_sequencer: durations must be 1..65535 and FRAC must match Q14");
    end

    function automatic logic [15:0] last_of(input sie_phase_e p);
        case (p)
            PH_PRE:         return 16'(PRE_CYCLES - 1);
            PH_IGNITION:    return 16'(IGNITION_CYCLES - 1);
            PH_PLATEAU:     return 16'(PLATEAU_CYCLES - 1);
            PH_PROPAGATION: return 16'(PROPAGATION_CYCLES - 1);
            PH_DECAY:       return 16'(DECAY_CYCLES - 1);
            PH_REFRACTORY:  return 16'(REFRACTORY_CYCLES - 1);
            default:        return '0;
        endcase
    endfunction

    sie_phase_e              phase_q, phase_d;
    logic [15:0]             cnt_q, cnt_d, event_q, event_d;
    logic                    active_q, active_d, pulse_q, pulse_d;
    logic signed [WIDTH-1:0] eff_thresh, eff_gate;
    logic                    cond, last, abort, ign_entry;
    logic                    r_up, r_down, r_hold, r_clear, r_force_one, r_force_zero;

    always_comb begin
        eff_thresh = (trigger_thresh == '0) ? WIDTH'(DEFAULT_TRIGGER_THRESH) : trigger_thresh;
        eff_gate = (r_gate == '0) ? WIDTH'(DEFAULT_R_GATE) : r_gate;
        cond = enable && !boundary_power[WIDTH-1] && !kuramoto_R[WIDTH-1] &&
               boundary_power >= eff_thresh && kuramoto_R >= eff_gate;
        last = cnt_q == last_of(phase_q);
        abort = !enable && (phase_q inside {PH_IGNITION, PH_PLATEAU, PH_PROPAGATION});
        phase_d = phase_q;
        cnt_d = cnt_q;
        if (clk_en) begin
            case (phase_q)
                PH_BASELINE: begin
                    phase_d = (force_trigger && enable) ? PH_IGNITION : cond ? PH_PRE : PH_BASELINE;
                    cnt_d = '0;
                end
                PH_PRE: begin
                    phase_d = !cond ? PH_BASELINE : last ? PH_IGNITION : PH_PRE;
                    cnt_d = (!cond || last) ? '0 : cnt_q + 16'd1;
                end
                PH_IGNITION, PH_PLATEAU, PH_PROPAGATION, PH_DECAY, PH_REFRACTORY: begin
                    phase_d = abort ? PH_DECAY
                            : !last ? phase_q
                            : (phase_q == PH_REFRACTORY) ? PH_BASELINE
                            : sie_phase_e'(phase_q + 3'd1);
                    cnt_d = (abort || last) ? '0 : cnt_q + 16'd1;
                end
                default: begin
                    phase_d = PH_BASELINE;
                    cnt_d = '0;
                end
            endcase
        end
        ign_entry = phase_d == PH_IGNITION && phase_q != PH_IGNITION;
        event_d = (ign_entry && event_q != 16'hFFFF) ? event_q + 16'd1 : event_q;
        active_d = phase_d inside {PH_IGNITION, PH_PLATEAU, PH_PROPAGATION};
        pulse_d = ign_entry;
        // An aborting tick asserts no ramp control, so the envelope carries into DECAY unchanged.
        r_clear = clk_en && (phase_q inside {PH_BASELINE, PH_PRE, PH_REFRACTORY, PH_ILLEGAL});
        r_up = clk_en && phase_q == PH_IGNITION && !abort;
        r_force_one = r_up && last;
        r_hold = clk_en && (phase_q inside {PH_PLATEAU, PH_PROPAGATION}) && !abort;
        r_down = clk_en && phase_q == PH_DECAY;
        r_force_zero = r_down && last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= PH_BASELINE;
            cnt_q    <= '0;
            event_q  <= '0;
            active_q <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            event_q  <= event_d;
            active_q <= active_d;
            pulse_q  <= pulse_d;
        end
    end

    sie_envelope_ramp #(
        .WIDTH (WIDTH),
        .UP    (ONE / IGNITION_CYCLES),
        .DN    (ONE / DECAY_CYCLES)
    ) u_ramp (
        .clk        (clk),
        .rst        (rst),
        .up         (r_up),
        .down       (r_down),
        .hold_one   (r_hold),
        .clear      (r_clear),
        .force_one  (r_force_one),
        .force_zero (r_force_zero),
        .env        (sie_envelope)
    );

    assign sie_phase      = phase_q;
    assign sie_active     = active_q;
    assign ignition_pulse = pulse_q;
    assign event_count    = event_q;

endmodule

// File: tb/tb_sie_phase_sequencer.sv
// tb_sie_phase_sequencer: directed scenarios plus randomized run against a per-tick reference model.
module tb_sie_phase_sequencer;

    localparam int W = 18;
    localparam int ONE = 16384;
    localparam int PRE = 4, IGN = 8, PLAT = 8, PROP = 4, DEC = 8, REFR = 16;
    localparam int UP = ONE / IGN, DN = ONE / DEC;
    localparam int Q_03 = 4915, Q_039 = 6390, Q_041 = 6717, Q_044 = 7209, Q_046 = 7537;
    localparam int Q_08 = 13107, Q_09 = 14746;

    logic clk = 1'b0, rst = 1'b0, clk_en = 1'b0, enable = 1'b0, force_trigger = 1'b0;
    logic signed [W-1:0] bp = '0, kr = '0, tt = '0, rg = '0;
    logic [2:0] sie_phase;
    logic sie_active, ignition_pulse;
    logic signed [W-1:0] sie_envelope;
    logic [15:0] event_count;

    int n_cmp = 0, n_bad = 0;
    int m_ph, m_cnt, m_env, m_evt;
    bit m_pulse;

    sie_phase_sequencer #(
        .WIDTH(W), .FRAC(14), .PRE_CYCLES(PRE), .IGNITION_CYCLES(IGN), .PLATEAU_CYCLES(PLAT),
        .PROPAGATION_CYCLES(PROP), .DECAY_CYCLES(DEC), .REFRACTORY_CYCLES(REFR),
        .DEFAULT_TRIGGER_THRESH(6554), .DEFAULT_R_GATE(7373)
    ) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .enable(enable), .force_trigger(force_trigger),
        .boundary_power(bp), .kuramoto_R(kr), .trigger_thresh(tt), .r_gate(rg),
        .sie_phase(sie_phase), .sie_active(sie_active), .sie_envelope(sie_envelope),
        .ignition_pulse(ignition_pulse), .event_count(event_count)
    );

    always #5 clk = ~clk;

    function automatic int dur(input int p);
        case (p)
            1: return PRE;
            2: return IGN;
            3: return PLAT;
            4: return PROP;
            5: return DEC;
            6: return REFR;
            default: return 1;
        endcase
    endfunction

    task automatic model_reset();
        m_ph = 0; m_cnt = 0; m_env = 0; m_evt = 0; m_pulse = 0;
    endtask

    // One clk edge of the reference: phase durations, thresholds and envelope slopes from the rules.
    task automatic model_tick();
        int th, gt, nph;
        bit c, last, abort;
        m_pulse = 0;
        if (!clk_en) return;
        th = (tt == 0) ? 6554 : int'(tt);
        gt = (rg == 0) ? 7373 : int'(rg);
        c = enable && bp >= 0 && kr >= 0 && int'(bp) >= th && int'(kr) >= gt;
        last = (m_cnt == dur(m_ph) - 1);
        abort = !enable && m_ph >= 2 && m_ph <= 4;
        nph = -1;
        case (m_ph)
            0: begin m_env = 0; nph = (force_trigger && enable) ? 2 : c ? 1 : 0; end
            1: begin m_env = 0; if (!c) nph = 0; else if (last) nph = 2; end
            2, 3, 4: begin
                if (abort) nph = 5;
                else begin
                    m_env = (m_ph != 2 || last) ? ONE : (m_env + UP > ONE ? ONE : m_env + UP);
                    if (last) nph = m_ph + 1;
                end
            end
            5: begin m_env = (last || m_env <= DN) ? 0 : m_env - DN; if (last) nph = 6; end
            6: begin m_env = 0; if (last) nph = 0; end
            default: nph = 0;
        endcase
        if (nph < 0) m_cnt++;
        else begin
            if (nph == 2) begin m_pulse = 1; if (m_evt < 65535) m_evt++; end
            m_ph = nph;
            m_cnt = 0;
        end
    endtask

    task automatic step(input bit ce);
        clk_en = ce;
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) step(1'b1);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        enable = 1'b1; force_trigger = 1'b1; bp = W'(Q_09); kr = W'(Q_08);
        #2;
        n_cmp++; if (sie_phase !== 3'd0) begin n_bad++; $display("FAIL reset_phase got %0d want 0", sie_phase); end
        n_cmp++; if (sie_envelope !== '0) begin n_bad++; $display("FAIL reset_env got %0d want 0", sie_envelope); end
        n_cmp++; if (event_count !== 16'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", event_count); end
        step(1'b1);
        step(1'b1);
        n_cmp++; if ({sie_phase, sie_active, ignition_pulse} !== 5'd0) begin
            n_bad++; $display("FAIL reset_held phase=%0d active=%0b pulse=%0b want 0/0/0", sie_phase, sie_active, ignition_pulse);
        end
        force_trigger = 1'b0; bp = '0; kr = '0;
        @(negedge clk) rst = 1'b0;
        model_reset();
    endtask

    task automatic test_no_trigger();
        enable = 1'b1; bp = W'(Q_09); kr = W'(Q_03);
        ticks(10);
        n_cmp++; if (sie_phase !== 3'd0) begin n_bad++; $display("FAIL low_r_phase got %0d want 0", sie_phase); end
        n_cmp++; if (event_count !== 16'd0) begin n_bad++; $display("FAIL low_r_count got %0d want 0", event_count); end
    endtask

    task automatic test_pre_ignition();
        kr = W'(Q_08);
        step(1'b1);
        n_cmp++; if (sie_phase !== 3'd1) begin n_bad++; $display("FAIL pre_enter phase=%0d want 1", sie_phase); end
        ticks(3);
        n_cmp++; if (sie_phase !== 3'd1 || ignition_pulse !== 1'b0) begin
            n_bad++; $display("FAIL pre_hold phase=%0d pulse=%0b want 1/0", sie_phase, ignition_pulse);
        end
        step(1'b1);
        n_cmp++; if (sie_phase !== 3'd2 || ignition_pulse !== 1'b1 || sie_active !== 1'b1) begin
            n_bad++; $display("FAIL ign_enter phase=%0d pulse=%0b active=%0b want 2/1/1", sie_phase, ignition_pulse, sie_active);
        end
        n_cmp++; if (event_count !== 16'd1) begin n_bad++; $display("FAIL ign_count got %0d want 1", event_count); end
        step(1'b0);
        n_cmp++; if (ignition_pulse !== 1'b0 || sie_phase !== 3'd2) begin
            n_bad++; $display("FAIL pulse_width pulse=%0b phase=%0d want 0/2", ignition_pulse, sie_phase);
        end
    endtask

    task automatic test_full_sequence();
        for (int k = 1; k <= IGN; k++) begin
            step(1'b1);
            n_cmp++; if (sie_envelope !== W'(k * UP) || sie_phase !== ((k < IGN) ? 3'd2 : 3'd3)) begin
                n_bad++; $display("FAIL ign_ramp k=%0d env=%0d phase=%0d want %0d", k, sie_envelope, sie_phase, k * UP);
            end
        end
        for (int j = 1; j <= PLAT + PROP; j++) begin
            step(1'b1);
            n_cmp++; if (sie_envelope !== W'(ONE) || sie_phase !== ((j < PLAT) ? 3'd3 : (j < PLAT + PROP) ? 3'd4 : 3'd5)
                         || sie_active !== (j < PLAT + PROP)) begin
                n_bad++; $display("FAIL hold j=%0d env=%0d phase=%0d active=%0b", j, sie_envelope, sie_phase, sie_active);
            end
        end
        for (int k = 1; k <= DEC; k++) begin
            step(1'b1);
            n_cmp++; if (sie_envelope !== W'(ONE - k * DN) || sie_phase !== ((k < DEC) ? 3'd5 : 3'd6) || sie_active !== 1'b0) begin
                n_bad++; $display("FAIL decay k=%0d env=%0d phase=%0d want %0d", k, sie_envelope, sie_phase, ONE - k * DN);
            end
        end
        for (int k = 1; k <= REFR; k++) begin
            step(1'b1);
            n_cmp++; if (sie_phase !== ((k < REFR) ? 3'd6 : 3'd0) || sie_envelope !== '0) begin
                n_bad++; $display("FAIL refr k=%0d phase=%0d env=%0d", k, sie_phase, sie_envelope);
            end
        end
    endtask

    task automatic test_cond_drop();
        ticks(3);
        kr = W'(Q_03);
        step(1'b1);
        n_cmp++; if (sie_phase !== 3'd0 || ignition_pulse !== 1'b0 || event_count !== 16'd1) begin
            n_bad++; $display("FAIL cond_drop phase=%0d pulse=%0b count=%0d want 0/0/1", sie_phase, ignition_pulse, event_count);
        end
    endtask

    task automatic test_abort_and_force();
        kr = W'(Q_08);
        ticks(PRE + 1 + IGN + 2);
        n_cmp++; if (sie_phase !== 3'd3) begin n_bad++; $display("FAIL abort_setup phase=%0d want 3", sie_phase); end
        enable = 1'b0;
        step(1'b1);
        n_cmp++; if (sie_phase !== 3'd5 || sie_envelope !== W'(ONE)) begin
            n_bad++; $display("FAIL abort_enter phase=%0d env=%0d want 5/%0d", sie_phase, sie_envelope, ONE);
        end
        for (int k = 1; k <= DEC; k++) begin
            step(1'b1);
            n_cmp++; if (sie_envelope !== W'(ONE - k * DN) || sie_phase !== ((k < DEC) ? 3'd5 : 3'd6)) begin
                n_bad++; $display("FAIL abort_decay k=%0d env=%0d phase=%0d", k, sie_envelope, sie_phase);
            end
        end
        enable = 1'b1; force_trigger = 1'b1; kr = W'(Q_03);
        for (int k = 1; k <= REFR; k++) begin
            step(1'b1);
            n_cmp++; if (sie_phase !== ((k < REFR) ? 3'd6 : 3'd0)) begin
                n_bad++; $display("FAIL force_in_refr k=%0d phase=%0d", k, sie_phase);
            end
        end
        step(1'b1);
        n_cmp++; if (sie_phase !== 3'd2 || ignition_pulse !== 1'b1 || event_count !== 16'd3) begin
            n_bad++; $display("FAIL forced_ign phase=%0d pulse=%0b count=%0d want 2/1/3", sie_phase, ignition_pulse, event_count);
        end
        force_trigger = 1'b0; enable = 1'b0;
        ticks(1 + DEC + REFR);
        n_cmp++; if (sie_phase !== 3'd0 || sie_envelope !== '0) begin
            n_bad++; $display("FAIL drain phase=%0d env=%0d want 0/0", sie_phase, sie_envelope);
        end
        enable = 1'b1;
    endtask

    task automatic test_async_reset_defaults();
        bp = W'(Q_09); kr = W'(Q_08);
        ticks(PRE + 1 + IGN + 3);
        n_cmp++; if (sie_phase !== 3'd3) begin n_bad++; $display("FAIL rst_setup phase=%0d want 3", sie_phase); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({sie_phase, sie_active, ignition_pulse} !== 5'd0 || sie_envelope !== '0 || event_count !== 16'd0) begin
            n_bad++; $display("FAIL async_rst phase=%0d active=%0b env=%0d count=%0d want all 0",
                              sie_phase, sie_active, sie_envelope, event_count);
        end
        bp = W'(Q_039);
        @(negedge clk) rst = 1'b0;
        model_reset();
        ticks(6);
        n_cmp++; if (sie_phase !== 3'd0) begin n_bad++; $display("FAIL dflt_thresh_039 phase=%0d want 0", sie_phase); end
        bp = W'(Q_041);
        step(1'b1);
        n_cmp++; if (sie_phase !== 3'd1) begin n_bad++; $display("FAIL dflt_thresh_041 phase=%0d want 1", sie_phase); end
        bp = W'(Q_09); kr = W'(Q_044);
        ticks(4);
        n_cmp++; if (sie_phase !== 3'd0) begin n_bad++; $display("FAIL dflt_gate_044 phase=%0d want 0", sie_phase); end
        kr = W'(Q_046);
        step(1'b1);
        n_cmp++; if (sie_phase !== 3'd1) begin n_bad++; $display("FAIL dflt_gate_046 phase=%0d want 1", sie_phase); end
        kr = W'(Q_03);
        step(1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                bp = ($urandom_range(0, 4) == 0) ? W'(-int'($urandom_range(1, 3000))) : W'($urandom_range(5500, 9000));
                kr = ($urandom_range(0, 4) == 0) ? W'(-int'($urandom_range(1, 3000))) : W'($urandom_range(6000, 9000));
            end
            if ($urandom_range(0, 63) == 0) begin
                tt = ($urandom_range(0, 2) == 0) ? W'(0) : ($urandom_range(0, 1) == 0) ? W'(-500) : W'($urandom_range(5000, 8000));
                rg = ($urandom_range(0, 2) == 0) ? W'(0) : ($urandom_range(0, 1) == 0) ? W'(-500) : W'($urandom_range(6000, 8000));
            end
            if ($urandom_range(0, 15) == 0) enable = ($urandom_range(0, 9) != 0);
            force_trigger = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 799) == 0) begin
                rst = 1'b1; #2 rst = 1'b0;
                model_reset();
            end
            step($urandom_range(0, 3) != 0);
            n_cmp++; if (sie_phase !== 3'(m_ph)) begin n_bad++; $display("FAIL rnd_phase i=%0d got %0d want %0d", i, sie_phase, m_ph); end
            n_cmp++; if (sie_envelope !== W'(m_env)) begin n_bad++; $display("FAIL rnd_env i=%0d got %0d want %0d", i, sie_envelope, m_env); end
            n_cmp++; if (sie_active !== (m_ph >= 2 && m_ph <= 4)) begin
                n_bad++; $display("FAIL rnd_active i=%0d got %0b phase_model=%0d", i, sie_active, m_ph);
            end
            n_cmp++; if (ignition_pulse !== m_pulse) begin n_bad++; $display("FAIL rnd_pulse i=%0d got %0b want %0b", i, ignition_pulse, m_pulse); end
            n_cmp++; if (event_count !== 16'(m_evt)) begin n_bad++; $display("FAIL rnd_count i=%0d got %0d want %0d", i, event_count, m_evt); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_no_trigger();
        test_pre_ignition();
        test_full_sequence();
        test_cond_drop();
        test_abort_and_force();
        test_async_reset_defaults();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
